shift_unit: RTL and testbench
=============================

SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 The block SHALL have these ports: Clock  input  1  single clock; all state changes on its rising edge.
REQ-002 Reset  input  1  asynchronous, active-low reset.
REQ-003 Start  input  1  request pulse, sampled on a rising Clock edge.
REQ-004 Hyrja  input  16  operand, captured when Start is accepted.
REQ-005 Shamt  input  4  shift amount 0..15, captured when Start is accepted.
REQ-006 S  input  3  ALU op code, captured when Start is accepted: 110 = SLL, 111 = SRA, 101 = SRL (only when SRL_EN is defined), any other code = pass-through.
REQ-007 Busy  output  1  high while the unit is shifting.
REQ-008 Done  output  1  one-cycle pulse when the result is valid.
REQ-009 Dalja  output  16  result register; it feeds the SLL/SRA inputs of the ALU result mux.

Function
REQ-010 The block SHALL implement a state machine with three states: IDLE, SHIFT and DONE.
REQ-011 In IDLE, when Start=1 at a rising edge, the block SHALL capture Hyrja into Dalja and load the counter with Shamt; this is the accept edge E0.
REQ-012 After E0, the next state SHALL be SHIFT if the op is a shift and Shamt≠0; otherwise it SHALL be DONE.
REQ-013 In SHIFT, each edge SHALL shift Dalja by one bit and decrement the counter; after the edge where the counter reaches 0, the next state SHALL be DONE.
REQ-014 SLL SHALL shift left with 0 filled in; SRA SHALL shift right with Dalja[15] replicated into bit 15; SRL SHALL shift right with 0 filled in.
REQ-015 Timing: Done SHALL be high for exactly the one cycle following edge E_Shamt (for Shamt=0 or a pass-through op, the cycle after E0).
REQ-016 Busy SHALL be 1 only in SHIFT; Done SHALL be 1 only in DONE; they are never both 1.
REQ-017 DONE SHALL always return to IDLE on the next edge.
REQ-018 Start SHALL be ignored in SHIFT and DONE; it is not queued; a back-to-back request is accepted at the earliest one edge after DONE.
REQ-019 Dalja SHALL hold its value from DONE until the next accepted Start.
REQ-020 Changes on Hyrja, Shamt or S after E0 SHALL not affect the operation in progress.
REQ-021 Arithmetic: there is no wrap-around; Shamt=15 SRA of a negative operand SHALL give 16'hFFFF.

Reset
REQ-022 Reset=0 SHALL immediately, without waiting for a clock edge, force: state IDLE, counter 0, Dalja 16'h0000, Busy 0, Done 0.
REQ-023 Reset asserted in the middle of an operation SHALL abort it with no Done pulse.
REQ-024 The first Start SHALL be accepted at the first rising edge after Reset deasserts.

Configuration
REQ-025 With the macro SHIFT_UNIT_SRL_EN defined, S=101 SHALL perform a logical right shift with Shamt+1 latency, the same as SLL/SRA.
REQ-026 Without SHIFT_UNIT_SRL_EN, S=101 SHALL be a pass-through op (Dalja=Hyrja, Done one cycle after E0), and no SRL logic SHALL be synthesised.

Verification
REQ-027 Hyrja=16'h0001, Shamt=4, S=110 -> Busy high for 4 cycles, then a Done pulse with Dalja=16'h0010.
REQ-028 Hyrja=16'h8000, Shamt=15, S=111 -> Done after 15 shift edges, Dalja=16'hFFFF; repeat with Hyrja=16'h4000 -> Dalja=16'h0000.
REQ-029 Hyrja=16'hABCD, Shamt=0, S=110, and separately S=000 with Shamt=7 -> Busy never high, Done in the cycle after E0, Dalja=16'hABCD.
REQ-030 Start held high continuously with Hyrja changing each cycle -> only the first request is processed, the next is accepted one edge after Done, and the result matches the operands captured at each accept edge.
REQ-031 Reset driven low mid-SHIFT (Shamt=8, after 3 edges) -> outputs go to 0 immediately, no Done pulse; a new Start after release completes normally.
REQ-032 S=101, Hyrja=16'h8000, Shamt=1 -> Dalja=16'h4000 after 1 shift with SHIFT_UNIT_SRL_EN defined; without it, Dalja=16'h8000 and Done one cycle after E0.

Source files
------------

// File: rtl/shift_unit.sv
// Serial one-bit-per-cycle shifter (SLL/SRA, optional SRL) for the ALU.
// Define SHIFT_UNIT_SRL_EN to add the logical right shift on S=101.
module shift_unit (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Start,
   input  logic [15:0] Hyrja,
   input  logic [3:0]  Shamt,
   input  logic [2:0]  S,
   output logic        Busy,
   output logic        Done,
   output logic [15:0] Dalja
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [1:0] OP_PASS = 2'd0;
   localparam logic [1:0] OP_SLL  = 2'd1;
   localparam logic [1:0] OP_SRA  = 2'd2;
`ifdef SHIFT_UNIT_SRL_EN
   localparam logic [1:0] OP_SRL  = 2'd3;
`endif

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic [1:0]  op;
   logic [1:0]  op_dec;
   logic [15:0] shifted;

   always_comb begin
      op_dec = OP_PASS;
      case (S)
         3'b110:  op_dec = OP_SLL;
         3'b111:  op_dec = OP_SRA;
`ifdef SHIFT_UNIT_SRL_EN
         3'b101:  op_dec = OP_SRL;
`endif
         default: op_dec = OP_PASS;
      endcase
   end

   always_comb begin
      shifted = Dalja;
      case (op)
         OP_SLL:  shifted = {Dalja[14:0], 1'b0};
         OP_SRA:  shifted = {Dalja[15], Dalja[15:1]};
`ifdef SHIFT_UNIT_SRL_EN
         OP_SRL:  shifted = {1'b0, Dalja[15:1]};
`endif
         default: shifted = Dalja;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
         op    <= OP_PASS;
         Dalja <= 16'h0000;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  Dalja <= Hyrja;
                  cnt   <= Shamt;
                  op    <= op_dec;
                  // zero-length shifts skip straight to DONE
                  if (op_dec != OP_PASS && Shamt != 4'd0)
                     state <= SHIFT;
                  else
                     state <= DONE;
               end
            end
            SHIFT: begin
               Dalja <= shifted;
               cnt   <= cnt - 4'd1;
               if (cnt == 4'd1)
                  state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign Busy = (state == SHIFT);
   assign Done = (state == DONE);

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit: vector table, scoreboard queue,
// back-to-back Start, and mid-operation reset sequences.
module tb_shift_unit;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Start;
   logic [15:0] Hyrja;
   logic [3:0]  Shamt;
   logic [2:0]  S;
   logic        Busy;
   logic        Done;
   logic [15:0] Dalja;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [15:0] h;
      logic [3:0]  sh;
      logic [2:0]  s;
      logic [15:0] e;
      int          lat;
   } vec_t;

   typedef struct {
      logic [15:0] dalja;
      int          lat;
   } exp_t;

   vec_t vt[10];
   exp_t sbq[$];

   shift_unit dut (
      .Clock(Clock),
      .Reset(Reset),
      .Start(Start),
      .Hyrja(Hyrja),
      .Shamt(Shamt),
      .S(S),
      .Busy(Busy),
      .Done(Done),
      .Dalja(Dalja)
   );

   always #5 Clock = ~Clock;

   task automatic check(input bit ok, input string nm,
                        input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   task automatic run_vec(input logic [15:0] h,
                          input logic [3:0] sh,
                          input logic [2:0] s,
                          input logic [15:0] e,
                          input int lat,
                          input bit nowait,
                          input string nm);
      exp_t x;
      int   bc;
      int   dc;
      bit   got;
      bit   both;
      if (!nowait) @(negedge Clock);
      Start = 1'b1;
      Hyrja = h;
      Shamt = sh;
      S     = s;
      x.dalja = e;
      x.lat   = lat;
      sbq.push_back(x);
      @(posedge Clock);
      #1;
      Start = 1'b0;
      Hyrja = ~h;
      Shamt = ~sh;
      S     = 3'b110;
      bc = 0;
      dc = 0;
      got = 1'b0;
      both = 1'b0;
      for (int c = 1; c <= 40 && !got; c++) begin
         @(negedge Clock);
         if (Busy && Done) both = 1'b1;
         if (Busy) bc++;
         if (Done) begin
            got = 1'b1;
            dc = c;
         end
      end
      check(!both, {nm, " busy_and_done"}, 32'(both), 0);
      if (!got) begin
         check(1'b0, {nm, " done_timeout"}, 0, 1);
         if (sbq.size() > 0) void'(sbq.pop_front());
      end else begin
         x = sbq.pop_front();
         check(Dalja == x.dalja, {nm, " dalja"}, 32'(Dalja), 32'(x.dalja));
         check(dc == x.lat + 1, {nm, " done_cycle"}, 32'(dc), 32'(x.lat + 1));
         check(bc == x.lat, {nm, " busy_cycles"}, 32'(bc), 32'(x.lat));
         @(negedge Clock);
         check(!Done, {nm, " done_one_cycle"}, 32'(Done), 0);
         check(Dalja == x.dalja, {nm, " dalja_hold"}, 32'(Dalja), 32'(x.dalja));
      end
   endtask

   initial begin
      exp_t        x;
      logic [15:0] hv;
      int          ndone;
      bit          stray;

      vt[0] = '{16'h0001, 4'd4,  3'b110, 16'h0010, 4};
      vt[1] = '{16'h8000, 4'd15, 3'b111, 16'hFFFF, 15};
      vt[2] = '{16'h4000, 4'd15, 3'b111, 16'h0000, 15};
      vt[3] = '{16'hABCD, 4'd0,  3'b110, 16'hABCD, 0};
      vt[4] = '{16'hABCD, 4'd7,  3'b000, 16'hABCD, 0};
`ifdef SHIFT_UNIT_SRL_EN
      vt[5] = '{16'h8000, 4'd1,  3'b101, 16'h4000, 1};
`else
      vt[5] = '{16'h8000, 4'd1,  3'b101, 16'h8000, 0};
`endif
      vt[6] = '{16'hF0F0, 4'd3,  3'b111, 16'hFE1E, 3};
      vt[7] = '{16'h1234, 4'd8,  3'b110, 16'h3400, 8};
      vt[8] = '{16'h8421, 4'd2,  3'b111, 16'hE108, 2};
      vt[9] = '{16'h00FF, 4'd5,  3'b011, 16'h00FF, 0};

      Reset = 1'b0;
      Start = 1'b1;
      Hyrja = 16'hFFFF;
      Shamt = 4'd3;
      S     = 3'b110;
      repeat (3) @(negedge Clock);
      check(Busy == 1'b0, "reset busy", 32'(Busy), 0);
      check(Done == 1'b0, "reset done", 32'(Done), 0);
      check(Dalja == 16'h0, "reset dalja", 32'(Dalja), 0);

      Reset = 1'b1;
      for (int i = 0; i < 10; i++)
         run_vec(vt[i].h, vt[i].sh, vt[i].s, vt[i].e,
                 vt[i].lat, i == 0, $sformatf("vec%0d", i));

      // Start held high: accept, 2 shifts, DONE, IDLE, accept again
      @(negedge Clock);
      ndone = 0;
      for (int k = 0; k <= 12; k++) begin
         if (k > 0) @(negedge Clock);
         if (Done) begin
            ndone++;
            if (sbq.size() > 0) begin
               x = sbq.pop_front();
               check(Dalja == x.dalja, $sformatf("b2b dalja%0d", ndone),
                     32'(Dalja), 32'(x.dalja));
            end else begin
               check(1'b0, "b2b extra_done", 32'(ndone), 3);
            end
         end
         hv = 16'h1357 + 16'(k) * 16'h0F1D;
         Hyrja = hv;
         Shamt = 4'd2;
         S     = 3'b110;
         Start = (k < 12);
         if (k < 12 && k % 4 == 0) begin
            x.dalja = hv << 2;
            x.lat   = 2;
            sbq.push_back(x);
         end
      end
      Start = 1'b0;
      check(ndone == 3, "b2b done_count", 32'(ndone), 3);
      check(sbq.size() == 0, "b2b queue_empty", 32'(sbq.size()), 0);
      repeat (6) @(negedge Clock);
      check(!Busy && !Done, "b2b idle_after",
            32'({Busy, Done}), 0);

      // reset in the middle of an 8-step shift
      @(negedge Clock);
      Start = 1'b1;
      Hyrja = 16'hFFFF;
      Shamt = 4'd8;
      S     = 3'b110;
      @(posedge Clock);
      #1;
      Start = 1'b0;
      repeat (3) @(posedge Clock);
      #1;
      check(Busy == 1'b1, "mid busy", 32'(Busy), 1);
      check(Dalja == 16'hFFF8, "mid dalja", 32'(Dalja), 32'h0000FFF8);
      Reset = 1'b0;
      #1;
      check(Busy == 1'b0, "async busy", 32'(Busy), 0);
      check(Done == 1'b0, "async done", 32'(Done), 0);
      check(Dalja == 16'h0, "async dalja", 32'(Dalja), 0);
      stray = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge Clock);
         if (Done || Busy) stray = 1'b1;
      end
      check(!stray, "abort no_done", 32'(stray), 0);
      Reset = 1'b1;
      run_vec(16'h0003, 4'd1, 3'b110, 16'h0006, 1, 1'b1, "after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1);
   end

endmodule
